// File: rtl/adc_pkg.sv
// Shared types and helpers for the serial ADC front end.
package adc_pkg;

    localparam int ADC_BITS = 16;

    typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

    function automatic logic [31:0] sext(input logic [ADC_BITS-1:0] v);
        return {{(32-ADC_BITS){v[ADC_BITS-1]}}, v};
    endfunction

endpackage

// File: rtl/adc_if.sv
// ADC serial pins plus the sample stream toward the consumer.
interface adc_if;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_sdata;
    logic [31:0] adc_in;
    logic        adc_valid;
    logic        adc_ready;

    modport master (output adc_cs_n, adc_sclk, adc_in, adc_valid,
                    input  adc_sdata, adc_ready);
    modport slave  (input  adc_cs_n, adc_sclk, adc_in, adc_valid,
                    output adc_sdata, adc_ready);
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; the read port reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic             do_push, do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign level   = wp - rp;
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the head slot the write lands in.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + ONE;
            if (do_pop)  rp <= rp + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rp[AW-1:0]];

endmodule

// File: rtl/adc_frontend.sv
// Periodic serial ADC capture: timer-triggered 16-bit shift-in, sign-extended into a sample FIFO.
module adc_frontend
    import adc_pkg::*;
#(
    parameter int SAMPLE_DIV = 64,
    parameter int SCLK_DIV   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        enable,
    input  logic                        ovf_clr,
    adc_if.master                       bus,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam logic [15:0] TMR_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [2:0]  DIV_LAST = 3'(SCLK_DIV - 1);

    state_t              state;
    logic [15:0]         tmr;
    logic [2:0]          div;
    logic [4:0]          tog;
    logic [ADC_BITS-1:0] sh;
    logic                cs_n, sclk;
    logic                trigger, push, full, empty, drop;

    assign trigger = enable && (tmr == TMR_LAST);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                tmr <= '0;
        else if (!enable || trigger) tmr <= '0;
        else                        tmr <= tmr + 16'd1;
    end

    // tog counts sclk edges; the 32nd edge is the final falling one.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            cs_n  <= 1'b1;
            sclk  <= 1'b0;
            div   <= '0;
            tog   <= '0;
            sh    <= '0;
        end else if (!enable) begin
            state <= IDLE;
            cs_n  <= 1'b1;
            sclk  <= 1'b0;
            div   <= '0;
            tog   <= '0;
        end else begin
            case (state)
                IDLE: if (trigger) begin
                    state <= SHIFT;
                    cs_n  <= 1'b0;
                    sclk  <= 1'b0;
                    div   <= '0;
                    tog   <= '0;
                end
                SHIFT: if (div == DIV_LAST) begin
                    div  <= '0;
                    sclk <= ~sclk;
                    tog  <= tog + 5'd1;
                    if (!sclk) sh <= {sh[ADC_BITS-2:0], bus.adc_sdata};
                    if (tog == 5'd31) begin
                        state <= PUSH;
                        cs_n  <= 1'b1;
                    end
                end else begin
                    div <= div + 3'd1;
                end
                PUSH:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.adc_cs_n = cs_n;
    assign bus.adc_sclk = sclk;
    assign bus.adc_valid = !empty;

    assign push = (state == PUSH) && enable;
    // A full FIFO still has a head, so any ready pop makes room.
    assign drop = push && full && !bus.adc_ready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)      overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (push),
        .pop    (bus.adc_ready),
        .wdata  (sext(sh)),
        .rdata  (bus.adc_in),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level)
    );

endmodule
